// File: rtl/mod_sq_pkg.sv
// mod_sq_pkg: shared width helpers, saturation limit and S3 frame state
package mod_sq_pkg;
  function automatic int sq_w(int width);
    return 2 * width + 1;
  endfunction
  function automatic int acc_w(int out_w, int acc_log2_max);
    return out_w + acc_log2_max;
  endfunction
  function automatic logic [63:0] sat_lim(int out_w);
    return (64'd1 << out_w) - 64'd1;
  endfunction
  typedef enum logic {IDLE, ACCUM} frame_state_t;
endpackage

// File: rtl/mod_squared_stream_if.sv
// mod_squared_stream_if: sample input and result output handshake bundle
interface mod_squared_stream_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 16,
  parameter int ACC_LOG2_MAX = 4
);
  logic in_valid, in_ready, in_last, out_valid, out_ready;
  logic [WIDTH-1:0] in_i, in_q;
  logic [OUT_W+ACC_LOG2_MAX-1:0] out_data;
  logic [ACC_LOG2_MAX:0] out_cnt;
  modport master(output in_valid, in_i, in_q, in_last, out_ready,
                 input in_ready, out_valid, out_data, out_cnt);
  modport slave(input in_valid, in_i, in_q, in_last, out_ready,
                output in_ready, out_valid, out_data, out_cnt);
endinterface

// File: rtl/mod_sq_core.sv
// mod_sq_core: mask/register (S1) and square (S2) stages sharing one enable; sum is combinational off S2
module mod_sq_core import mod_sq_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic in_valid,
  input  logic in_last,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-1:0] mask,
  output logic s2_valid,
  output logic s2_last,
  output logic [sq_w(WIDTH)-1:0] sum
);
  logic v1, l1;
  logic signed [WIDTH-1:0] i1, q1;
  logic [2*WIDTH-1:0] ii, qq;
  always_ff @(posedge clk)
    if (reset) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      i1 <= '0;
      q1 <= '0;
      s2_valid <= 1'b0;
      s2_last <= 1'b0;
      ii <= '0;
      qq <= '0;
    end else if (en) begin
      v1 <= in_valid;
      l1 <= in_last;
      i1 <= in_i & mask;
      q1 <= in_q & mask;
      s2_valid <= v1;
      s2_last <= l1;
      ii <= (2*WIDTH)'(i1) * (2*WIDTH)'(i1);
      qq <= (2*WIDTH)'(q1) * (2*WIDTH)'(q1);
    end
  assign sum = {1'b0, ii} + {1'b0, qq};
endmodule

// File: rtl/mod_squared_stream.sv
// mod_squared_stream: I^2+Q^2 rescale, saturate and 2^N non-coherent integration.
// Define MOD_SQ_ROUND_EN for round-half-up instead of truncation when dropping FRAC bits.
module mod_squared_stream import mod_sq_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int FRAC = 4,
  parameter int OUT_W = 16,
  parameter int ACC_LOG2_MAX = 4
) (
  input logic clk,
  input logic reset,
  mod_squared_stream_if.slave bus,
  input logic [WIDTH-1:0] conf_bit_mask,
  input logic [$clog2(ACC_LOG2_MAX+1)-1:0] acc_log2
);
  localparam int SQ_W = sq_w(WIDTH);
  localparam int ACC_W = acc_w(OUT_W, ACC_LOG2_MAX);
  localparam int N_W = $clog2(ACC_LOG2_MAX + 1);
  logic adv, s2_valid, s2_last, emit;
  logic [SQ_W-1:0] sum;
  logic [SQ_W:0] shifted;
  logic [OUT_W-1:0] scaled;
  logic [N_W-1:0] n, n_hold;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_LOG2_MAX:0] cnt, cnt_nxt;
  frame_state_t state, state_nxt;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  mod_sq_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .reset(reset),
    .en(adv),
    .in_valid(bus.in_valid),
    .in_last(bus.in_last),
    .in_i(bus.in_i),
    .in_q(bus.in_q),
    .mask(conf_bit_mask),
    .s2_valid(s2_valid),
    .s2_last(s2_last),
    .sum(sum)
  );
`ifdef MOD_SQ_ROUND_EN
  assign shifted = ({1'b0, sum} + (SQ_W+1)'((2 ** FRAC) >> 1)) >> FRAC;
`else
  assign shifted = {1'b0, sum} >> FRAC;
`endif
  // integration length is latched by the first sample of a frame and held until it closes
  always_comb begin
    scaled = 64'(shifted) > sat_lim(OUT_W) ? '1 : OUT_W'(shifted);
    n = state == IDLE ? (acc_log2 > N_W'(ACC_LOG2_MAX) ? N_W'(ACC_LOG2_MAX) : acc_log2) : n_hold;
    acc_nxt = acc + ACC_W'(scaled);
    cnt_nxt = cnt + (ACC_LOG2_MAX+1)'(1);
    emit = cnt_nxt == ((ACC_LOG2_MAX+1)'(1) << n) || s2_last;
    state_nxt = s2_valid ? (emit ? IDLE : ACCUM) : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_cnt <= '0;
      acc <= '0;
      cnt <= '0;
      n_hold <= '0;
      state <= IDLE;
    end else if (adv) begin
      bus.out_valid <= s2_valid && emit;
      state <= state_nxt;
      if (s2_valid && emit) begin
        bus.out_data <= acc_nxt;
        bus.out_cnt <= cnt_nxt;
        acc <= '0;
        cnt <= '0;
      end else if (s2_valid) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        n_hold <= n;
      end
    end
endmodule

// File: tb/tb_mod_squared_stream.sv
// tb_mod_squared_stream: directed literal checks plus randomized stream against a queue-based frame model
module tb_mod_squared_stream;
  localparam int WIDTH = 8;
  localparam int FRAC = 4;
  localparam int OUT_W = 16;
  localparam int AM = 4;
  logic clk = 1'b0;
  logic reset;
  logic [WIDTH-1:0] mask;
  logic [2:0] acc_log2;
  int n_chk = 0, n_pass = 0;
  longint exp_d[$], exp_c[$];
  longint fsum = 0, s_m;
  int fcnt = 0, fn = 0;
  mod_squared_stream_if #(.WIDTH(WIDTH), .OUT_W(OUT_W), .ACC_LOG2_MAX(AM)) bus();
  mod_squared_stream_if #(.WIDTH(WIDTH), .OUT_W(10), .ACC_LOG2_MAX(AM)) bus10();
  assign bus10.in_valid = bus.in_valid;
  assign bus10.in_i = bus.in_i;
  assign bus10.in_q = bus.in_q;
  assign bus10.in_last = bus.in_last;
  assign bus10.out_ready = bus.out_ready;
  mod_squared_stream #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(OUT_W), .ACC_LOG2_MAX(AM)) dut (
    .clk(clk), .reset(reset), .bus(bus), .conf_bit_mask(mask), .acc_log2(acc_log2));
  mod_squared_stream #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(10), .ACC_LOG2_MAX(AM)) dut10 (
    .clk(clk), .reset(reset), .bus(bus10), .conf_bit_mask(mask), .acc_log2(acc_log2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask
  function automatic longint scale(input logic [7:0] i, input logic [7:0] q, input logic [7:0] m);
    longint a, b, s;
    a = longint'($signed(i & m));
    b = longint'($signed(q & m));
    s = a * a + b * b;
`ifdef MOD_SQ_ROUND_EN
    s = (s + (2 ** FRAC) / 2) / (2 ** FRAC);
`else
    s = s / (2 ** FRAC);
`endif
    return s > 65535 ? 65535 : s;
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      exp_d.delete();
      exp_c.delete();
      fsum = 0;
      fcnt = 0;
    end else begin
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid) begin
        if (exp_d.size() == 0) chk("unexpected_out", bus.out_valid, 0);
        else begin
          chk("stream_data", bus.out_data, exp_d[0]);
          chk("stream_cnt", bus.out_cnt, exp_c[0]);
          if (exp_c[0] == 1) chk("sat10", bus10.out_data, exp_d[0] > 1023 ? 1023 : exp_d[0]);
          if (bus.out_ready) begin
            void'(exp_d.pop_front());
            void'(exp_c.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        s_m = scale(bus.in_i, bus.in_q, mask);
        if (fcnt == 0) fn = int'(acc_log2);
        fsum += s_m;
        fcnt++;
        if (fcnt == (1 << fn) || bus.in_last) begin
          exp_d.push_back(fsum);
          exp_c.push_back(longint'(fcnt));
          fsum = 0;
          fcnt = 0;
        end
      end
    end
  end
  task automatic push_sample(input logic [7:0] i, input logic [7:0] q, input logic last);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_i = i;
    bus.in_q = q;
    bus.in_last = last;
    do begin @(negedge clk); k++; end while (!bus.in_ready && k < 50);
    chk("accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic wait_out(input longint d, input longint c, input int lat_exp);
    int lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 20);
    chk("out_valid", bus.out_valid, 1);
    chk("out_data", bus.out_data, d);
    chk("out_cnt", bus.out_cnt, c);
    if (lat_exp > 0) chk("latency", lat, lat_exp);
    @(posedge clk); #1;
  endtask
  initial begin
    reset = 1'b1;
    mask = 8'hFF;
    acc_log2 = 3'd0;
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    push_sample(8'h10, 8'h10, 1'b0);
    wait_out(32, 1, 3);
    push_sample(8'h80, 8'h80, 1'b0);
    wait_out(2048, 1, 3);
    chk("sat10_direct", bus10.out_data, 1023);
    mask = 8'hF0;
    push_sample(8'h1F, 8'h00, 1'b0);
    wait_out(16, 1, 3);
    mask = 8'hFF;
    push_sample(8'h03, 8'h00, 1'b0);
`ifdef MOD_SQ_ROUND_EN
    wait_out(1, 1, 3);
`else
    wait_out(0, 1, 3);
`endif
    push_sample(8'h10, 8'h10, 1'b1);
    wait_out(32, 1, 3);
    acc_log2 = 3'd2;
    repeat (4) push_sample(8'h10, 8'h10, 1'b0);
    wait_out(128, 4, 3);
    push_sample(8'h10, 8'h10, 1'b1);
    wait_out(32, 1, 3);
    repeat (2) push_sample(8'h10, 8'h10, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    repeat (4) push_sample(8'h10, 8'h10, 1'b0);
    wait_out(128, 4, 3);
    for (int p = 0; p < 6; p++) begin
      acc_log2 = 3'($urandom_range(0, 4));
      for (int c = 0; c < 400; c++) begin
        bus.in_valid = $urandom_range(0, 9) < 7;
        bus.in_i = 8'($urandom);
        bus.in_q = 8'($urandom);
        bus.in_last = $urandom_range(0, 9) == 0;
        mask = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
        bus.out_ready = (c % 50) < 6 ? 1'b0 : ($urandom_range(0, 9) < 7);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
    end
    chk("queue_drained", exp_d.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mod_squared_stream.md
Name: mod_squared_stream

Overview:
- Streaming fixed-point modulus-squared unit for complex radar samples: computes I²+Q² per sample, rescales to the input fixed-point format, and optionally integrates non-coherently over 2^N samples.
- Successor to the single-register magnitude unit, with configurable width, a valid/ready handshake with backpressure, saturation, and an accumulation mode.
- Sits between the range/Doppler data path and the detection (CFAR) stage.

Parameters:
- WIDTH, 8, signed I/Q sample width.
- FRAC, 4, fractional bits of I/Q and of the rescaled square (0 ≤ FRAC < WIDTH).
- OUT_W, 16, width of the rescaled single-sample magnitude-squared; result saturates to this width.
- ACC_LOG2_MAX, 4, maximum log2 accumulation length.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit can accept a sample this cycle.
- in_i  in  WIDTH  signed in-phase component.
- in_q  in  WIDTH  signed quadrature component.
- in_last  in  1  last sample of the current integration frame; forces an early flush.
- conf_bit_mask  in  WIDTH  precision mask, ANDed onto I and Q before squaring.
- acc_log2  in  $clog2(ACC_LOG2_MAX+1)  integration length 2^acc_log2; 0 means pass-through.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W+ACC_LOG2_MAX  unsigned result, zero-extended.
- out_cnt  out  ACC_LOG2_MAX+1  number of samples integrated into out_data.

Behaviour:
- Reset: synchronous, active-high. Clears out_valid, out_data, out_cnt, all stage valids, the accumulator and the sample counter. in_ready is 1 in the cycle after reset is released.
- Reset mid-frame discards any partial accumulation.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv. A sample is accepted when in_valid && in_ready.
- When adv = 0, all stages hold, and out_data/out_cnt remain stable.
- S1 (register): capture in_i & conf_bit_mask, in_q & conf_bit_mask, in_last, and a valid bit.
- S2 (square): compute signed products i*i and q*q, each 2*WIDTH bits, and register them.
- S3 (sum and scale):
  - sum = i² + q², 2*WIDTH+1 bits unsigned.
  - scaled = sum >> FRAC (truncation).
  - If scaled > 2^OUT_W − 1, clamp to 2^OUT_W − 1.
- Pass-through (acc_log2 = 0): out_data = scaled and out_cnt = 1. Latency is 3 cycles from acceptance to out_valid, with no stalls.
- Accumulate (acc_log2 = N > 0):
  - The accumulator adds scaled for each S3-valid sample and counts samples.
  - Emit when count = 2^N or when the sample's last flag is set. out_data = running sum including that sample; out_cnt = count.
  - The accumulator and count clear in the same cycle as the emit.
  - No output is produced for non-final samples.
- acc_log2 is sampled when the first sample of a frame enters S3. Changes mid-frame take effect at the next frame.
- in_last with acc_log2 = 0 has no effect.
- The accumulator cannot overflow: 2^ACC_LOG2_MAX × (2^OUT_W − 1) fits the output width.
- Fully pipelined: 1 sample/cycle throughput while out_ready = 1.

Optional Feature:
- Macro: MOD_SQ_ROUND_EN.
- Defined: round-half-up when dropping FRAC bits, i.e. scaled = (sum + 2^(FRAC−1)) >> FRAC, then saturate.
- Undefined: truncation as specified in Behaviour. Latency is identical in both cases.

Decomposition:
- Package mod_sq_pkg holds:
  - localparam functions for SQ_W = 2*WIDTH+1 and ACC_W = OUT_W+ACC_LOG2_MAX;
  - the saturation-limit constant;
  - an enum for the S3 frame state: IDLE (no open frame) and ACCUM (partial frame held).
- One natural sub-module, mod_sq_core: the S1–S2 mask, square and sum datapath with stage valids and enable. The top keeps scaling, accumulation and handshake.

Test Plan:
- Pass-through, i=0x10, q=0x10, mask 0xFF, acc_log2=0 -> out_data=32 and out_cnt=1, 3 cycles after acceptance.
- i=0x80, q=0x80, mask 0xFF, OUT_W=10 -> sum 32768, scaled 2048, saturated out_data=1023. With default OUT_W=16 -> 2048.
- Mask and rounding:
  - i=0x1F, q=0x00, mask 0xF0 -> out_data=16.
  - i=0x03, q=0x00 -> out_data=0 when truncating, 1 with MOD_SQ_ROUND_EN.
- Accumulation, acc_log2=2, four samples i=q=0x10 -> one output, out_data=128, out_cnt=4. A fifth sample with in_last=1 -> out_data=32, out_cnt=1.
- Backpressure: 8 back-to-back samples with out_ready held low for 5 cycles -> in_ready=0 while out_valid && !out_ready, out_data stable, no sample lost or duplicated, order preserved.
- Reset asserted after 2 of 4 accumulated samples -> out_valid=0 next cycle; the following 4 samples produce out_cnt=4 with no residue from before reset.
